// File: rtl/nes_bus_pkg.sv
// Shared CPU/PPU bus definitions: address regions, responder FSM states and
// the region base addresses used by the address decoders.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_PPU,
        REG_APU,
        REG_NONE,
        REG_ROM
    } region_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PER_WAIT = 2'd1,
        PER_DONE = 2'd2
    } state_e;

    localparam logic [15:0] PPU_BASE  = 16'h2000;
    localparam logic [15:0] APU_BASE  = 16'h4000;
    localparam logic [15:0] NONE_BASE = 16'h4020;
    localparam logic [15:0] ROM_BASE  = 16'h8000;

    localparam logic PER_SEL_PPU = 1'b0;
    localparam logic PER_SEL_APU = 1'b1;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational CPU address decoder: region plus the local index inside
// the RAM, ROM and peripheral register windows.
module bus_addr_decode
    import nes_bus_pkg::*;
#(
    parameter int RAM_AW = 11,
    parameter int PRG_AW = 15
) (
    input  logic [15:0]       addr,
    output region_e           region,
    output logic [RAM_AW-1:0] ram_idx,
    output logic [PRG_AW-1:0] rom_idx,
    output logic [4:0]        reg_idx
);

    // RAM and ROM mirror by simply dropping the upper address bits.
    assign ram_idx = addr[RAM_AW-1:0];
    assign rom_idx = addr[PRG_AW-1:0];

    // Region select by ascending base address; PPU regs mirror every 8 bytes.
    always_comb begin
        region  = REG_NONE;
        reg_idx = 5'd0;
        if (addr < PPU_BASE) begin
            region = REG_RAM;
        end else if (addr < APU_BASE) begin
            region  = REG_PPU;
            reg_idx = {2'b00, addr[2:0]};
        end else if (addr < NONE_BASE) begin
            region  = REG_APU;
            reg_idx = addr[4:0];
        end else if (addr < ROM_BASE) begin
            region = REG_NONE;
        end else begin
            region = REG_ROM;
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the CPU bus: work RAM, preloadable PRG ROM,
// open-bus emulation and a stalling req/ack bridge to the peripherals.
//
// Peripheral handshake: per_req is a level held from the cycle after the
// CPU address is captured until the edge that samples per_ack=1 (or the
// timeout). per_sel/per_addr/per_we/per_wdata are stable whenever per_req=1.
// per_ack is a single-cycle pulse, with per_rdata valid in that same cycle;
// per_ack is only honoured while the FSM is in PER_WAIT.
module cpu_bus_responder
    import nes_bus_pkg::*;
#(
    parameter int PRG_AW  = 15,
    parameter int RAM_AW  = 11,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_ph2,
    input  logic              rst,
    input  logic [15:0]       Addr_bus,
    input  logic              rw,
    input  logic [7:0]        Data_wr,
    output logic [7:0]        Data_bus,
    output logic              rdy,
    output logic              per_req,
    output logic              per_sel,
    output logic [4:0]        per_addr,
    output logic              per_we,
    output logic [7:0]        per_wdata,
    input  logic [7:0]        per_rdata,
    input  logic              per_ack,
    input  logic              ld_en,
    input  logic [PRG_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              timeout_err,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [7:0] ram [0:(2**RAM_AW)-1];
    logic [7:0] rom [0:(2**PRG_AW)-1];

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [PRG_AW-1:0] rom_idx;
    logic [4:0]        reg_idx;
    logic [7:0]        ram_rd;
    logic [7:0]        rom_rd;

    state_e     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0] open_bus, open_bus_d;
    logic [7:0] data_d;
    logic       rdy_d, req_d, sel_d, we_d, to_d;
    logic [4:0] paddr_d;
    logic [7:0] pwdata_d;
    logic       ram_we;
    logic       mem_access;
    logic       is_per;

    bus_addr_decode #(
        .RAM_AW (RAM_AW),
        .PRG_AW (PRG_AW)
    ) u_decode (
        .addr    (Addr_bus),
        .region  (region),
        .ram_idx (ram_idx),
        .rom_idx (rom_idx),
        .reg_idx (reg_idx)
    );

    assign ram_rd    = ram[ram_idx];
    assign rom_rd    = rom[rom_idx];
    assign is_per    = (region == REG_PPU) || (region == REG_APU);
    assign state_dbg = state;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        open_bus_d = open_bus;
        data_d     = Data_bus;
        rdy_d      = rdy;
        req_d      = per_req;
        sel_d      = per_sel;
        paddr_d    = per_addr;
        we_d       = per_we;
        pwdata_d   = per_wdata;
        to_d       = 1'b0;
        ram_we     = 1'b0;
        mem_access = 1'b0;

        case (state)
            IDLE: begin
                if (is_per) begin
                    req_d    = 1'b1;
                    sel_d    = (region == REG_APU) ? PER_SEL_APU : PER_SEL_PPU;
                    paddr_d  = reg_idx;
                    we_d     = !rw;
                    pwdata_d = Data_wr;
                    rdy_d    = 1'b0;
                    cnt_d    = CNT_W'(TIMEOUT);
                    state_d  = PER_WAIT;
                end else begin
                    mem_access = 1'b1;
                end
            end
            PER_WAIT: begin
                if (per_ack) begin
                    // Ack takes priority over a simultaneous expiry.
                    req_d = 1'b0;
                    if (per_we) begin
                        open_bus_d = per_wdata;
                    end else begin
                        data_d     = per_rdata;
                        open_bus_d = per_rdata;
                    end
                    rdy_d   = 1'b1;
                    state_d = PER_DONE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        req_d   = 1'b0;
                        data_d  = open_bus;
                        rdy_d   = 1'b1;
                        to_d    = 1'b1;
                        state_d = PER_DONE;
                    end
                end
            end
            PER_DONE: begin
                // The CPU may still present the peripheral address here; never re-trigger.
                mem_access = !is_per;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mem_access) begin
            if (rw) begin
                case (region)
                    REG_RAM: begin
                        data_d     = ram_rd;
                        open_bus_d = ram_rd;
                    end
                    REG_ROM: begin
                        data_d     = rom_rd;
                        open_bus_d = rom_rd;
                    end
                    default: data_d = open_bus;
                endcase
            end else begin
                open_bus_d = Data_wr;
                ram_we     = (region == REG_RAM);
            end
        end
    end

    // State and registered bus outputs with synchronous reset.
    always_ff @(posedge clk_ph2) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            open_bus    <= 8'h00;
            Data_bus    <= 8'h00;
            rdy         <= 1'b1;
            per_req     <= 1'b0;
            per_sel     <= 1'b0;
            per_addr    <= 5'd0;
            per_we      <= 1'b0;
            per_wdata   <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            open_bus    <= open_bus_d;
            Data_bus    <= data_d;
            rdy         <= rdy_d;
            per_req     <= req_d;
            per_sel     <= sel_d;
            per_addr    <= paddr_d;
            per_we      <= we_d;
            per_wdata   <= pwdata_d;
            timeout_err <= to_d;
        end
    end

    // Work RAM write port, suppressed while in reset.
    always_ff @(posedge clk_ph2) begin
        if (ram_we && !rst) begin
            ram[ram_idx] <= Data_wr;
        end
    end

    // ROM preload port, independent of the CPU side.
    always_ff @(posedge clk_ph2) begin
        if (ld_en) begin
            rom[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: vector table for RAM/ROM/open-bus
// traffic plus hand-written peripheral, timeout and reset sequences.
module tb_cpu_bus_responder;

    logic        clk_ph2 = 1'b0;
    logic        rst;
    logic [15:0] Addr_bus;
    logic        rw;
    logic [7:0]  Data_wr;
    logic [7:0]  Data_bus;
    logic        rdy;
    logic        per_req;
    logic        per_sel;
    logic [4:0]  per_addr;
    logic        per_we;
    logic [7:0]  per_wdata;
    logic [7:0]  per_rdata;
    logic        per_ack;
    logic        ld_en;
    logic [14:0] ld_addr;
    logic [7:0]  ld_data;
    logic        timeout_err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[17];

    cpu_bus_responder dut (
        .clk_ph2     (clk_ph2),
        .rst         (rst),
        .Addr_bus    (Addr_bus),
        .rw          (rw),
        .Data_wr     (Data_wr),
        .Data_bus    (Data_bus),
        .rdy         (rdy),
        .per_req     (per_req),
        .per_sel     (per_sel),
        .per_addr    (per_addr),
        .per_we      (per_we),
        .per_wdata   (per_wdata),
        .per_rdata   (per_rdata),
        .per_ack     (per_ack),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // Clock: period 10.
    always #5 clk_ph2 = ~clk_ph2;

    // One active edge, then return to the falling edge for sampling/driving.
    task automatic cycle();
        @(posedge clk_ph2);
        @(negedge clk_ph2);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cpu_drive(input logic [15:0] a, input logic r, input logic [7:0] d);
        Addr_bus = a;
        rw       = r;
        Data_wr  = d;
    endtask

    task automatic rom_load(input logic [14:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        cycle();
        ld_en   = 1'b0;
    endtask

    initial begin
        int rdy_low;
        int req_cycles;
        int pulses;
        logic seen_rdy;
        logic [7:0] cap_data;

        rst       = 1'b1;
        per_ack   = 1'b0;
        per_rdata = 8'h00;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = 8'h00;
        cpu_drive(16'h5000, 1'b1, 8'h00);
        cycle();
        cycle();

        // Reset values.
        check("rst_data_bus", Data_bus, 8'h00);
        check("rst_rdy", rdy, 1'b1);
        check("rst_per_req", per_req, 1'b0);
        check("rst_per_we", per_we, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        rst = 1'b0;

        rom_load(15'h7FFC, 8'h00);
        rom_load(15'h7FFD, 8'h80);
        rom_load(15'h0000, 8'hA5);

        vecs[0]  = '{16'h0005, 1'b0, 8'h5A, 8'h00};
        vecs[1]  = '{16'h0805, 1'b1, 8'h00, 8'h5A};
        vecs[2]  = '{16'h1805, 1'b1, 8'h00, 8'h5A};
        vecs[3]  = '{16'hFFFC, 1'b1, 8'h00, 8'h00};
        vecs[4]  = '{16'hFFFD, 1'b1, 8'h00, 8'h80};
        vecs[5]  = '{16'h8000, 1'b0, 8'h12, 8'h80};
        vecs[6]  = '{16'h5000, 1'b1, 8'h00, 8'h12};
        vecs[7]  = '{16'h8000, 1'b1, 8'h00, 8'hA5};
        vecs[8]  = '{16'h07FF, 1'b0, 8'hC3, 8'hA5};
        vecs[9]  = '{16'h4020, 1'b1, 8'h00, 8'hC3};
        vecs[10] = '{16'h1FFF, 1'b1, 8'h00, 8'hC3};
        vecs[11] = '{16'h7FFF, 1'b1, 8'h00, 8'hC3};
        vecs[12] = '{16'h0000, 1'b0, 8'h77, 8'hC3};
        vecs[13] = '{16'h1800, 1'b1, 8'h00, 8'h77};
        vecs[14] = '{16'h5000, 1'b0, 8'hE1, 8'h77};
        vecs[15] = '{16'h4020, 1'b1, 8'h00, 8'hE1};
        vecs[16] = '{16'h0805, 1'b1, 8'h00, 8'h5A};

        for (int i = 0; i < 17; i++) begin
            cpu_drive(vecs[i].addr, vecs[i].rw, vecs[i].wdata);
            exp_q.push_back(vecs[i].exp_data);
            cycle();
            check($sformatf("vec%0d_data", i), Data_bus, exp_q.pop_front());
            check($sformatf("vec%0d_rdy", i), rdy, 1'b1);
            check($sformatf("vec%0d_req", i), per_req, 1'b0);
        end

        // Preload collides with a CPU read of the same byte: old byte wins.
        cpu_drive(16'hFFFC, 1'b1, 8'h00);
        rom_load(15'h7FFC, 8'h55);
        check("collide_old", Data_bus, 8'h00);
        cycle();
        check("collide_new", Data_bus, 8'h55);

        // PPU read of $2002, ack on the fourth edge after capture.
        cpu_drive(16'h2002, 1'b1, 8'h00);
        cycle();
        check("ppu_rd_req", per_req, 1'b1);
        check("ppu_rd_sel", per_sel, 1'b0);
        check("ppu_rd_addr", per_addr, 5'd2);
        check("ppu_rd_we", per_we, 1'b0);
        check("ppu_rd_state", state_dbg, 2'd1);
        rdy_low = (rdy == 1'b0) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("ppu_rd_hold%0d", i), per_req, 1'b1);
            if (rdy == 1'b0) rdy_low++;
        end
        per_ack   = 1'b1;
        per_rdata = 8'h80;
        cycle();
        per_ack   = 1'b0;
        check("ppu_rd_rdy_low_cycles", 16'(rdy_low), 16'd4);
        check("ppu_rd_done_rdy", rdy, 1'b1);
        check("ppu_rd_done_req", per_req, 1'b0);
        check("ppu_rd_data", Data_bus, 8'h80);
        check("ppu_rd_done_state", state_dbg, 2'd2);
        cycle();
        check("ppu_rd_no_retrigger", per_req, 1'b0);
        check("ppu_rd_back_idle", state_dbg, 2'd0);
        check("ppu_rd_data_hold", Data_bus, 8'h80);

        // APU write $3F to $4015.
        cpu_drive(16'h4015, 1'b0, 8'h3F);
        cycle();
        check("apu_wr_req", per_req, 1'b1);
        check("apu_wr_sel", per_sel, 1'b1);
        check("apu_wr_addr", per_addr, 5'h15);
        check("apu_wr_we", per_we, 1'b1);
        check("apu_wr_wdata", per_wdata, 8'h3F);
        check("apu_wr_rdy", rdy, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check($sformatf("apu_wr_hold%0d", i), per_req, 1'b1);
        end
        per_ack = 1'b1;
        cycle();
        per_ack = 1'b0;
        check("apu_wr_done_req", per_req, 1'b0);
        check("apu_wr_done_rdy", rdy, 1'b1);
        cpu_drive(16'h5000, 1'b1, 8'h00);
        cycle();
        check("apu_wr_openbus", Data_bus, 8'h3F);

        // PPU read of $2007 with no ack: timeout.
        cpu_drive(16'h2007, 1'b1, 8'h00);
        req_cycles = 0;
        pulses     = 0;
        seen_rdy   = 1'b0;
        cap_data   = 8'hXX;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i == 0) check("to_addr", per_addr, 5'd7);
            if (per_req) req_cycles++;
            if (timeout_err) pulses++;
            if (i > 0 && rdy && !seen_rdy) begin
                seen_rdy = 1'b1;
                cap_data = Data_bus;
                cpu_drive(16'h5000, 1'b1, 8'h00);
            end
        end
        check("to_req_cycles", 16'(req_cycles), 16'd16);
        check("to_pulses", 16'(pulses), 16'd1);
        check("to_rdy_back", 16'(seen_rdy), 16'd1);
        check("to_data", cap_data, 8'h3F);

        // Ack arrives on the same edge the counter would expire: ack wins.
        cpu_drive(16'h2000, 1'b1, 8'h00);
        cycle();
        for (int i = 0; i < 15; i++) cycle();
        check("race_still_waiting", per_req, 1'b1);
        per_ack   = 1'b1;
        per_rdata = 8'h6C;
        cycle();
        per_ack   = 1'b0;
        cpu_drive(16'h5000, 1'b1, 8'h00);
        check("race_no_timeout", timeout_err, 1'b0);
        check("race_data", Data_bus, 8'h6C);
        check("race_rdy", rdy, 1'b1);
        check("race_state", state_dbg, 2'd2);

        // Reset during PER_WAIT, then a stray ack.
        cpu_drive(16'h2002, 1'b1, 8'h00);
        cycle();
        cycle();
        check("rstmid_waiting", per_req, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cpu_drive(16'h5000, 1'b1, 8'h00);
        check("rstmid_req", per_req, 1'b0);
        check("rstmid_rdy", rdy, 1'b1);
        check("rstmid_data", Data_bus, 8'h00);
        check("rstmid_state", state_dbg, 2'd0);
        cycle();
        per_ack   = 1'b1;
        per_rdata = 8'hFF;
        cycle();
        per_ack   = 1'b0;
        check("late_ack_data", Data_bus, 8'h00);
        check("late_ack_req", per_req, 1'b0);
        check("late_ack_state", state_dbg, 2'd0);
        check("late_ack_rdy", rdy, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory-side responder for the CPU address/data bus: it answers every CPU bus cycle.
- Decodes Addr_bus into three targets: internal 2 KB work RAM (mirrored), preloadable PRG ROM, and a register window for PPU/APU/IO peripherals.
- Peripheral accesses use a req/ack handshake; the CPU is stalled through RDY until the access completes.
- Unmapped reads return the open-bus value (the last byte transferred).

Parameters:
- PRG_AW, 15, PRG ROM address width; 15 gives 32 KB at $8000-$FFFF, 14 gives 16 KB mirrored at $C000.
- RAM_AW, 11, work RAM address width; 11 gives 2 KB mirrored across $0000-$1FFF.
- TIMEOUT, 16, maximum cycles spent waiting for per_ack before the access is aborted.

Ports:
- clk_ph2  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Addr_bus  in  16  CPU address.
- rw  in  1  1 = CPU read, 0 = CPU write.
- Data_wr  in  8  CPU write data.
- Data_bus  out  8  registered read data to the CPU.
- rdy  out  1  1 = CPU may advance; 0 = CPU must hold its address and rw.
- per_req  out  1  peripheral request, level-held until ack or timeout.
- per_sel  out  1  0 = PPU regs ($2000-$3FFF, addr&7), 1 = APU/IO ($4000-$401F, addr&$1F).
- per_addr  out  5  peripheral register index.
- per_we  out  1  peripheral write strobe qualifier, valid with per_req.
- per_wdata  out  8  peripheral write data.
- per_rdata  in  8  peripheral read data, valid with per_ack.
- per_ack  in  1  single-cycle completion from the peripheral.
- ld_en  in  1  ROM preload write enable.
- ld_addr  in  PRG_AW  ROM preload address.
- ld_data  in  8  ROM preload data.
- timeout_err  out  1  one-cycle pulse when a peripheral access is aborted.

Behaviour:
- Reset values: Data_bus=$00, open-bus register=$00, rdy=1, per_req=0, per_we=0, per_sel=0, per_addr=0, per_wdata=0, timeout_err=0, state=IDLE, timeout counter=0. RAM and ROM contents are not reset.
- Address decode:
  - $0000-$1FFF: RAM at Addr[RAM_AW-1:0].
  - $2000-$3FFF: PPU window.
  - $4000-$401F: APU/IO window.
  - $4020-$7FFF: unmapped.
  - $8000-$FFFF: ROM at Addr[PRG_AW-1:0].
- RAM/ROM read: in IDLE with rw=1, Data_bus and the open-bus register are loaded at the sampling edge. Data is stable for the CPU on the following edge, i.e. 1-cycle latency. rdy stays 1.
- RAM write: in IDLE with rw=0, the write completes at the sampling edge. The open-bus register takes Data_wr.
- ROM write from the CPU: ignored, except the open-bus register takes Data_wr.
- Unmapped read: Data_bus = open-bus register. Unmapped write: updates the open-bus register only.
- ld_en: writes ROM at ld_addr. It is independent of the CPU port; if ld_en and a CPU ROM read hit the same address in one cycle, the read returns the old byte.
- FSM states: IDLE, PER_WAIT, PER_DONE.
  - IDLE: on a peripheral-window decode, register per_req=1 plus per_sel, per_addr, per_we=!rw and per_wdata; drive rdy=0; load the counter with TIMEOUT; go to PER_WAIT.
  - PER_WAIT, per_ack=1: drop per_req; for a read, load Data_bus and the open-bus register from per_rdata; for a write, the open-bus register takes per_wdata. Set rdy=1 and go to PER_DONE.
  - PER_WAIT, per_ack=0: decrement the counter. When it reaches 0: drop per_req, set Data_bus = open-bus register, set rdy=1, pulse timeout_err, go to PER_DONE.
  - PER_WAIT, ack and expiry in the same cycle: ack wins and no timeout_err is raised.
  - PER_DONE: exactly one cycle. No new peripheral request is started, which prevents re-triggering on the held address. RAM/ROM accesses are still served normally. Return to IDLE.
- per_ack outside PER_WAIT: ignored.
- Addr_bus/rw changes while rdy=0: a protocol violation. The captured request stands, and the block does not re-sample until it is back in IDLE.
- rst asserted mid-access: every state returns to its reset value at that edge and per_req drops immediately. A late per_ack afterwards is ignored.
- Back-to-back peripheral accesses: minimum spacing is 3 cycles (IDLE → WAIT → DONE).

Decomposition:
- Shared package (nes_bus_pkg):
  - region enum {REG_RAM, REG_PPU, REG_APU, REG_NONE, REG_ROM};
  - FSM state enum;
  - region base addresses $2000, $4000, $4020, $8000;
  - PER_SEL_PPU/PER_SEL_APU constants.
- Sub-module bus_addr_decode: combinational Addr_bus → region plus local index. It is reusable by the future PPU-bus responder.

Test Plan:
- After reset, write $5A to $0005, then read $0805 → Data_bus=$5A one cycle after sampling (mirror), rdy held 1 throughout.
- Preload ROM $7FFC=$00, $7FFD=$80 via ld_en, then read $FFFC/$FFFD → $00, $80. Then CPU write $12 to $8000 → ROM unchanged, next read of $5000 returns $12.
- Read $2002 with per_ack after 3 cycles, per_rdata=$80 → per_sel=0, per_addr=2, per_we=0, rdy=0 for 4 cycles, Data_bus=$80; the held address does not create a second per_req in PER_DONE.
- Write $3F to $4015 → per_sel=1, per_addr=$15, per_we=1, per_wdata=$3F; per_req is held until ack.
- Read $2007 with no ack and TIMEOUT=16 → per_req high for 16 cycles, one timeout_err pulse, Data_bus = prior open-bus value, rdy back to 1.
- Assert rst during PER_WAIT, then give per_ack 2 cycles later → per_req=0 and rdy=1 right after the reset edge, the ack is ignored, and Data_bus=$00.
